// File: rtl/player_motion_ctrl.sv
// Per-player motion controller for the grid arena.
// Turns debounced direction/bomb levels into a bounded grid position, a facing
// direction and a movement state. Moves are rate-limited in game ticks, a stun
// pulse locks the player out for a fixed number of ticks, and a bomb press
// raises a request (with the latched cell) that is held until acknowledged.
//
// Ports:
//   clock, reset             system clock, asynchronous active-high reset
//   tick                     one-clock game-rate enable
//   dir_left/right/up/down   held direction levels (left > right > up > down)
//   bomb_btn                 bomb button level, rising edge detected on clock
//   stun_hit                 one-cycle stun pulse
//   bomb_ack                 board accepted the pending bomb request
//   bomb_req, bomb_x/y       bomb request and the cell latched at request time
//   pos_x, pos_y             current cell
//   facing                   0 left, 1 right, 2 up, 3 down
//   state                    0 idle, 1..4 moving L/R/U/D, 5 stunned
//   anim                     {bomb_req, state}
module player_motion_ctrl #(
  parameter int unsigned GRID_W        = 16,
  parameter int unsigned GRID_H        = 16,
  parameter int unsigned COORD_W       = 6,
  parameter int unsigned START_X       = 0,
  parameter int unsigned START_Y       = 0,
  parameter int unsigned MOVE_COOLDOWN = 3,
  parameter int unsigned STUN_TICKS    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               dir_left,
  input  logic               dir_right,
  input  logic               dir_up,
  input  logic               dir_down,
  input  logic               bomb_btn,
  input  logic               stun_hit,
  input  logic               bomb_ack,
  output logic               bomb_req,
  output logic [COORD_W-1:0] bomb_x,
  output logic [COORD_W-1:0] bomb_y,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         facing,
  output logic [2:0]         state,
  output logic [3:0]         anim
);

  localparam int unsigned CoolW = (MOVE_COOLDOWN > 0) ? $clog2(MOVE_COOLDOWN + 1) : 1;
  localparam int unsigned StunW = $clog2(STUN_TICKS + 1);

  localparam logic [COORD_W-1:0] MaxX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] MaxY = COORD_W'(GRID_H - 1);

  localparam logic [1:0] FaceLeft  = 2'd0;
  localparam logic [1:0] FaceRight = 2'd1;
  localparam logic [1:0] FaceUp    = 2'd2;
  localparam logic [1:0] FaceDown  = 2'd3;

  typedef enum logic [2:0] {
    StStationary = 3'd0,
    StMoveLeft   = 3'd1,
    StMoveRight  = 3'd2,
    StMoveUp     = 3'd3,
    StMoveDown   = 3'd4,
    StStunned    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [COORD_W-1:0] bomb_x_q, bomb_x_d, bomb_y_q, bomb_y_d;
  logic [1:0]         facing_q, facing_d;
  logic               bomb_req_q, bomb_req_d;
  logic [3:0]         anim_q, anim_d;
  logic [CoolW-1:0]   cool_q, cool_d;
  logic [StunW-1:0]   stun_q, stun_d;
  logic               btn_q;

  logic       btn_rise;
  logic       dir_valid;
  logic [1:0] dir_sel;

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    bomb_x_d   = bomb_x_q;
    bomb_y_d   = bomb_y_q;
    facing_d   = facing_q;
    bomb_req_d = bomb_req_q;
    cool_d     = cool_q;
    stun_d     = stun_q;
    btn_rise   = bomb_btn & ~btn_q;
    dir_valid  = 1'b1;
    dir_sel    = FaceLeft;

    if (dir_left) begin
      dir_sel = FaceLeft;
    end else if (dir_right) begin
      dir_sel = FaceRight;
    end else if (dir_up) begin
      dir_sel = FaceUp;
    end else if (dir_down) begin
      dir_sel = FaceDown;
    end else begin
      dir_valid = 1'b0;
    end

    // Stun wins over any tick on the same cycle; re-hits while stunned are ignored.
    if (stun_hit && (state_q != StStunned)) begin
      state_d = StStunned;
      stun_d  = StunW'(STUN_TICKS);
      cool_d  = '0;
    end else if (state_q == StStunned) begin
      if (tick) begin
        stun_d = stun_q - StunW'(1);
        if (stun_q == StunW'(1)) begin
          state_d = StStationary;
        end
      end
    end else if (tick) begin
      if (dir_valid) begin
        facing_d = dir_sel;
        unique case (dir_sel)
          FaceLeft:  state_d = StMoveLeft;
          FaceRight: state_d = StMoveRight;
          FaceUp:    state_d = StMoveUp;
          default:   state_d = StMoveDown;
        endcase
      end else begin
        state_d = StStationary;
      end

      if (cool_q != '0) begin
        cool_d = cool_q - CoolW'(1);
      end else if (dir_valid) begin
        // A wall-blocked attempt still costs a cooldown period.
        cool_d = CoolW'(MOVE_COOLDOWN);
        // Up decreases Y (row 0 is the top of the board).
        unique case (dir_sel)
          FaceLeft:  if (pos_x_q != '0)  pos_x_d = pos_x_q - COORD_W'(1);
          FaceRight: if (pos_x_q != MaxX) pos_x_d = pos_x_q + COORD_W'(1);
          FaceUp:    if (pos_y_q != '0)  pos_y_d = pos_y_q - COORD_W'(1);
          default:   if (pos_y_q != MaxY) pos_y_d = pos_y_q + COORD_W'(1);
        endcase
      end
    end

    // A pending request is never dropped by a stun; new presses need idle, unstunned.
    if (bomb_req_q) begin
      if (bomb_ack) begin
        bomb_req_d = 1'b0;
      end
    end else if (btn_rise && (state_q != StStunned) && !stun_hit) begin
      bomb_req_d = 1'b1;
      bomb_x_d   = pos_x_q;
      bomb_y_d   = pos_y_q;
    end

    anim_d = {bomb_req_d, state_d};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StStationary;
      pos_x_q    <= COORD_W'(START_X);
      pos_y_q    <= COORD_W'(START_Y);
      bomb_x_q   <= '0;
      bomb_y_q   <= '0;
      facing_q   <= FaceDown;
      bomb_req_q <= 1'b0;
      anim_q     <= '0;
      cool_q     <= '0;
      stun_q     <= '0;
      btn_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      bomb_x_q   <= bomb_x_d;
      bomb_y_q   <= bomb_y_d;
      facing_q   <= facing_d;
      bomb_req_q <= bomb_req_d;
      anim_q     <= anim_d;
      cool_q     <= cool_d;
      stun_q     <= stun_d;
      btn_q      <= bomb_btn;
    end
  end

  assign bomb_req = bomb_req_q;
  assign bomb_x   = bomb_x_q;
  assign bomb_y   = bomb_y_q;
  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign facing   = facing_q;
  assign state    = state_q;
  assign anim     = anim_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl. Expected values are pushed onto a
// scoreboard queue alongside each stimulus step and popped/compared after the
// clock edge (or asynchronous reset) that should produce them.
// Two instances share all inputs: u_dut (start 0,0, cooldown 3, stun 4) and
// u_corner (start 15,15, cooldown 0, stun 4) for the saturation case.
module tb_player_motion_ctrl;

  localparam int unsigned CW = 6;

  localparam logic [3:0] DN = 4'b0000;
  localparam logic [3:0] DL = 4'b1000;
  localparam logic [3:0] DR = 4'b0100;
  localparam logic [3:0] DD = 4'b0001;

  localparam int unsigned SPx = 0, SPy = 1, SFace = 2, SState = 3, SReq = 4;
  localparam int unsigned SBx = 5, SBy = 6, SAnim = 7, SCPx = 8, SCPy = 9;
  localparam int unsigned SCState = 10, SCFace = 11;

  logic clock = 1'b0;
  logic reset;
  logic tick, dir_left, dir_right, dir_up, dir_down, bomb_btn, stun_hit, bomb_ack;

  logic          bomb_req, c_bomb_req;
  logic [CW-1:0] bomb_x, bomb_y, pos_x, pos_y;
  logic [CW-1:0] c_bomb_x, c_bomb_y, c_pos_x, c_pos_y;
  logic [1:0]    facing, c_facing;
  logic [2:0]    state, c_state;
  logic [3:0]    anim, c_anim;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [7:0]  val;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  player_motion_ctrl #(
    .GRID_W(16), .GRID_H(16), .COORD_W(CW), .START_X(0), .START_Y(0),
    .MOVE_COOLDOWN(3), .STUN_TICKS(4)
  ) u_dut (
    .clock(clock), .reset(reset), .tick(tick),
    .dir_left(dir_left), .dir_right(dir_right), .dir_up(dir_up), .dir_down(dir_down),
    .bomb_btn(bomb_btn), .stun_hit(stun_hit), .bomb_ack(bomb_ack),
    .bomb_req(bomb_req), .bomb_x(bomb_x), .bomb_y(bomb_y),
    .pos_x(pos_x), .pos_y(pos_y), .facing(facing), .state(state), .anim(anim)
  );

  player_motion_ctrl #(
    .GRID_W(16), .GRID_H(16), .COORD_W(CW), .START_X(15), .START_Y(15),
    .MOVE_COOLDOWN(0), .STUN_TICKS(4)
  ) u_corner (
    .clock(clock), .reset(reset), .tick(tick),
    .dir_left(dir_left), .dir_right(dir_right), .dir_up(dir_up), .dir_down(dir_down),
    .bomb_btn(bomb_btn), .stun_hit(stun_hit), .bomb_ack(bomb_ack),
    .bomb_req(c_bomb_req), .bomb_x(c_bomb_x), .bomb_y(c_bomb_y),
    .pos_x(c_pos_x), .pos_y(c_pos_y), .facing(c_facing), .state(c_state), .anim(c_anim)
  );

  function automatic logic [7:0] observe(input int unsigned sel);
    case (sel)
      SPx:     return 8'(pos_x);
      SPy:     return 8'(pos_y);
      SFace:   return 8'(facing);
      SState:  return 8'(state);
      SReq:    return 8'(bomb_req);
      SBx:     return 8'(bomb_x);
      SBy:     return 8'(bomb_y);
      SAnim:   return 8'(anim);
      SCPx:    return 8'(c_pos_x);
      SCPy:    return 8'(c_pos_y);
      SCState: return 8'(c_state);
      SCFace:  return 8'(c_facing);
      default: return 8'hxx;
    endcase
  endfunction

  task automatic chk(input string tag, input int unsigned sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, then check.
  task automatic step(input logic t, input logic [3:0] dirs, input logic b,
                      input logic s, input logic a);
    tick = t;
    {dir_left, dir_right, dir_up, dir_down} = dirs;
    bomb_btn = b;
    stun_hit = s;
    bomb_ack = a;
    @(posedge clock);
    #1;
    drain();
  endtask

  initial begin
    reset = 1'b1;
    tick = 1'b0;
    {dir_left, dir_right, dir_up, dir_down} = DN;
    bomb_btn = 1'b0;
    stun_hit = 1'b0;
    bomb_ack = 1'b0;
    #2;
    chk("rst_px", SPx, 8'd0);     chk("rst_py", SPy, 8'd0);
    chk("rst_face", SFace, 8'd3); chk("rst_state", SState, 8'd0);
    chk("rst_req", SReq, 8'd0);   chk("rst_bx", SBx, 8'd0);
    chk("rst_by", SBy, 8'd0);     chk("rst_anim", SAnim, 8'd0);
    chk("rst_cpx", SCPx, 8'd15);  chk("rst_cpy", SCPy, 8'd15);
    drain();
    @(posedge clock);
    #1 reset = 1'b0;

    // Right+down held, tick every cycle: right wins; main moves every 4th tick,
    // corner instance is pinned at the right wall.
    for (int i = 1; i <= 10; i++) begin
      if (i == 1) begin
        chk("mv_t1_px", SPx, 8'd1); chk("mv_t1_state", SState, 8'd2);
        chk("mv_t1_face", SFace, 8'd1);
      end
      if (i == 4) chk("mv_t4_px", SPx, 8'd1);
      if (i == 5) chk("mv_t5_px", SPx, 8'd2);
      if (i == 8) chk("mv_t8_px", SPx, 8'd2);
      if (i == 9) chk("mv_t9_px", SPx, 8'd3);
      if (i == 10) begin
        chk("mv_t10_px", SPx, 8'd3);   chk("mv_t10_py", SPy, 8'd0);
        chk("cor_px", SCPx, 8'd15);    chk("cor_py", SCPy, 8'd15);
        chk("cor_state", SCState, 8'd2); chk("cor_face", SCFace, 8'd1);
      end
      step(1'b1, DR | DD, 1'b0, 1'b0, 1'b0);
    end

    // Stun coincident with a tick: no move, stunned for 4 ticks, re-hit ignored.
    chk("stun_state", SState, 8'd5); chk("stun_px", SPx, 8'd3);
    step(1'b1, DL, 1'b0, 1'b1, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      chk("stun_frozen_px", SPx, 8'd3);
      chk("stun_state_t", SState, (j == 4) ? 8'd0 : 8'd5);
      step(1'b1, DL, 1'b0, (j == 2), 1'b0);
    end
    chk("post_stun_px", SPx, 8'd2); chk("post_stun_state", SState, 8'd1);
    chk("post_stun_face", SFace, 8'd0);
    step(1'b1, DL, 1'b0, 1'b0, 1'b0);

    // Walk to (7,3).
    for (int k = 0; k < 20; k++) step(1'b1, DR, 1'b0, 1'b0, 1'b0);
    chk("walk_px", SPx, 8'd7);
    drain();
    for (int k = 0; k < 12; k++) step(1'b1, DD, 1'b0, 1'b0, 1'b0);
    chk("walk_py", SPy, 8'd3); chk("walk_state", SState, 8'd4); chk("walk_face", SFace, 8'd3);
    drain();

    // Bomb at (7,3) while walking right; second press ignored; ack on 6th edge.
    chk("bomb_req1", SReq, 8'd1); chk("bomb_bx1", SBx, 8'd7); chk("bomb_by1", SBy, 8'd3);
    chk("bomb_anim1", SAnim, 8'd10);
    step(1'b1, DR, 1'b1, 1'b0, 1'b0);
    chk("bomb_req2", SReq, 8'd1);
    step(1'b1, DR, 1'b0, 1'b0, 1'b0);
    chk("bomb_repress_req", SReq, 8'd1); chk("bomb_repress_bx", SBx, 8'd7);
    step(1'b1, DR, 1'b1, 1'b0, 1'b0);
    chk("bomb_moved_px", SPx, 8'd8); chk("bomb_hold_bx", SBx, 8'd7);
    chk("bomb_hold_by", SBy, 8'd3);
    step(1'b1, DR, 1'b1, 1'b0, 1'b0);
    chk("bomb_req5", SReq, 8'd1); chk("bomb_anim5", SAnim, 8'd10);
    step(1'b1, DR, 1'b1, 1'b0, 1'b0);
    chk("bomb_acked", SReq, 8'd0); chk("bomb_anim_ack", SAnim, 8'd2);
    step(1'b1, DR, 1'b0, 1'b0, 1'b1);
    chk("bomb_next_req", SReq, 8'd1); chk("bomb_next_bx", SBx, 8'd8);
    chk("bomb_next_by", SBy, 8'd3);
    step(1'b0, DN, 1'b1, 1'b0, 1'b0);
    chk("bomb_next_ack", SReq, 8'd0);
    step(1'b0, DN, 1'b0, 1'b0, 1'b1);

    // Stun and press on the same edge: press discarded.
    chk("sb_state", SState, 8'd5); chk("sb_req", SReq, 8'd0);
    step(1'b0, DN, 1'b1, 1'b1, 1'b0);
    step(1'b0, DN, 1'b0, 1'b0, 1'b0);
    chk("stunned_press_req", SReq, 8'd0);
    step(1'b0, DN, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk("sb_stun_state", SState, (k == 4) ? 8'd0 : 8'd5);
      step(1'b1, DN, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, DN, 1'b0, 1'b0, 1'b0);
    chk("rq_req", SReq, 8'd1); chk("rq_bx", SBx, 8'd8);
    step(1'b0, DN, 1'b1, 1'b0, 1'b0);
    chk("rq_stun_state", SState, 8'd5); chk("rq_stun_req", SReq, 8'd1);
    chk("rq_stun_anim", SAnim, 8'd13);
    step(1'b0, DN, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle, away from any clock edge.
    stun_hit = 1'b0;
    tick = 1'b1;
    {dir_left, dir_right, dir_up, dir_down} = DR;
    #3 reset = 1'b1;
    #1;
    chk("arst_px", SPx, 8'd0);     chk("arst_py", SPy, 8'd0);
    chk("arst_state", SState, 8'd0); chk("arst_face", SFace, 8'd3);
    chk("arst_req", SReq, 8'd0);   chk("arst_bx", SBx, 8'd0);
    chk("arst_by", SBy, 8'd0);     chk("arst_anim", SAnim, 8'd0);
    chk("arst_cpx", SCPx, 8'd15);
    drain();
    @(posedge clock);
    #1 reset = 1'b0;
    chk("after_rst_px", SPx, 8'd1); chk("after_rst_state", SState, 8'd2);
    chk("after_rst_face", SFace, 8'd1);
    step(1'b1, DR, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
# player_motion_ctrl

Parametrised per-player controller for the grid arena. It converts debounced direction and bomb buttons into a bounded grid position, a facing direction and a movement state, and rate-limits moves to a configurable number of game ticks. It applies a timed stun lockout and issues a held bomb-placement request to the board logic. One instance per player, between the input debouncers and the game-board arbiter, which also owns the stun detector.

## Interface
Parameters:
- GRID_W, 16, board width in cells; legal X is 0..GRID_W-1
- GRID_H, 16, board height in cells; legal Y is 0..GRID_H-1
- COORD_W, 6, coordinate width; 2^COORD_W >= max(GRID_W, GRID_H)
- START_X, 0, X position after reset
- START_Y, 0, Y position after reset
- MOVE_COOLDOWN, 3, ticks skipped after each move (0 allows a move on every tick)
- STUN_TICKS, 32, stun duration in ticks; must be >= 1

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  game-rate enable, one clock wide
- dir_left, dir_right, dir_up, dir_down  in  1 each  held direction levels
- bomb_btn  in  1  bomb button level
- stun_hit  in  1  one-cycle stun pulse from the stun detector
- bomb_ack  in  1  board has accepted the bomb request
- bomb_req  out  1  bomb placement request
- bomb_x, bomb_y  out  COORD_W each  cell latched at request time
- pos_x, pos_y  out  COORD_W each  current cell
- facing  out  2  last direction: 0 left, 1 right, 2 up, 3 down
- state  out  3  0 STATIONARY, 1 MOVE_LEFT, 2 MOVE_RIGHT, 3 MOVE_UP, 4 MOVE_DOWN, 5 STUNNED
- anim  out  4  {bomb_req, state}

## Operation
- All outputs are registered. Reset values: pos = START_X/START_Y, state = STATIONARY, facing = 3, bomb_req = 0, bomb_x/bomb_y = 0, anim = 0. Internal cooldown, stun and edge-detect registers clear to 0.
- Direction selection: left > right > up > down. Only the highest-priority asserted direction counts. Opposite directions held together resolve by this priority.
- The stun_hit check runs every clock. If the block is not STUNNED, the next state is STUNNED, the stun counter loads STUN_TICKS and the cooldown counter clears. stun_hit while already STUNNED is ignored; there is no extension.
- Stun has priority. On a cycle with both stun_hit and tick, no move is evaluated.
- In STUNNED, each tick decrements the stun counter. The tick that takes it from 1 to 0 moves state to STATIONARY. Direction inputs are ignored while STUNNED.
- Movement, on a tick while not STUNNED:
  - state becomes MOVE_<dir> for the selected direction, or STATIONARY if none is held.
  - facing updates to the selected direction.
  - If the cooldown counter is nonzero, it decrements and pos is unchanged.
  - If the cooldown counter is 0 and a direction is selected, the counter loads MOVE_COOLDOWN and pos steps by 1, saturating at 0 and at GRID_W-1 / GRID_H-1.
  - A move blocked by a wall still loads the cooldown.
- Bomb:
  - A rising edge of bomb_btn, detected on the clock (not gated by tick), while bomb_req = 0 and the block is not STUNNED sets bomb_req and latches bomb_x/bomb_y = current pos.
  - bomb_req holds until a cycle with bomb_ack = 1, then clears on the next edge.
  - Presses while bomb_req = 1 or while STUNNED are discarded.
  - A press coincident with stun_hit is discarded.
  - bomb_ack while bomb_req = 0 has no effect.
  - A stun arriving with bomb_req = 1 leaves the request pending.

## Timing
- tick-to-pos latency: pos updates on the clock edge that samples tick; it is visible the following cycle.
- A held direction moves once every MOVE_COOLDOWN+1 ticks. The first move happens on the first tick after reset or after a stun ends.
- stun_hit at edge N gives state = 5 after edge N. The stun then lasts exactly STUN_TICKS ticks.
- bomb press edge sampled at edge N gives bomb_req = 1 after edge N. bomb_ack sampled at edge M gives bomb_req = 0 after edge M. The earliest new request is at edge M+1.
- reset asserted mid-operation forces all reset values immediately, independent of clock.

## Test plan
- Reset, hold dir_right, tick every cycle, MOVE_COOLDOWN=3 -> pos_x goes 0→1 on tick 1, →2 on tick 5, →3 on tick 9; state = 2; facing = 1.
- Start at (15,15), hold dir_down and dir_right for 10 ticks, MOVE_COOLDOWN=0 -> pos stays (15,15) because right wins priority and saturates; state = 2.
- stun_hit while holding dir_left, STUN_TICKS=4 -> state = 5 and pos frozen for 4 ticks; STATIONARY after the 4th tick; move on tick 5; a second stun_hit during the stun does not extend it.
- Press bomb at (7,3), bomb_ack after 5 cycles -> bomb_req high for 5 cycles with bomb_x/bomb_y = 7/3 throughout (even if the player moves); a second press meanwhile is ignored; anim[3] tracks bomb_req.
- Same-cycle stun_hit and bomb_btn rising edge -> bomb_req stays 0 and state = 5.
- Assert reset mid-move with bomb_req = 1 and the stun active -> all outputs return to reset values asynchronously; the next tick with a held direction moves immediately.
